serial_subtractor_4_bit: RTL
============================

// Module: serial_subtractor_4_bit
// PURPOSE
//   Bit-serial subtractor: computes Diff = A - B, LSB first, one bit per clock.
//   A single borrow flip-flop is reused across bits, the sequential counterpart
//   of the ripple-carry adder. It sits beside the adder in the arithmetic
//   datapath and uses a start/busy/done handshake for operand acceptance and
//   result delivery.
// PARAMETERS
//   WIDTH  4  operand/result width in bits (>=2)
// PORTS
//   clk    input   1      rising-edge clock
//   reset  input   1      synchronous, active-high reset
//   start  input   1      request: latch A,B and begin subtraction
//   A      input   WIDTH  minuend (unsigned), sampled on accepted start
//   B      input   WIDTH  subtrahend (unsigned), sampled on accepted start
//   busy   output  1      high while a subtraction is in progress
//   done   output  1      one-cycle pulse: Diff/Bout valid
//   Diff   output  WIDTH  result A-B mod 2^WIDTH, held until next done
//   Bout   output  1      borrow out; 1 iff A < B (unsigned)
// BEHAVIOUR
//   Reset (clk edge with reset=1): state=IDLE; busy=0, done=0, Diff=0, Bout=0.
//     Internal shift regs, borrow and bit counter are cleared. Reset has
//     priority over start and aborts any operation in progress; no done pulse.
//   FSM states: IDLE, SHIFT, DONE.
//   - IDLE: start=1 -> latch A,B into shift regs; borrow=0; cnt=0; go to SHIFT.
//   - SHIFT: busy=1. Each cycle: a=a_sr[0], b=b_sr[0].
//       d = a ^ b ^ br
//       br_next = (~a & b) | (~(a ^ b) & br)
//       d is shifted in at the MSB of d_sr; a_sr/b_sr shift right; cnt++.
//       When cnt==WIDTH-1 (last bit): go to DONE.
//       Diff <= final d_sr and Bout <= br_next on that same edge.
//   - DONE: done=1, busy=0 for exactly one cycle. start=1 here is accepted
//     (behaves as in IDLE, goes to SHIFT); otherwise go to IDLE.
//   start while in SHIFT is ignored; operands are not re-sampled.
//   A/B may change freely after the accepting edge.
//   Latency: start sampled at edge 0 -> busy high cycles 1..WIDTH,
//     done high in cycle WIDTH+1 (5 for WIDTH=4). Throughput: one op per
//     WIDTH+1 cycles with back-to-back start.
//   Diff/Bout change only on the edge entering DONE (or on reset); they are
//     stable through the following IDLE/SHIFT cycles.
//   Counter width is $clog2(WIDTH); no state beyond the three listed.
// TESTING
//   1. A=9, B=3, start pulse -> done at 5th cycle, Diff=6, Bout=0, busy high 4 cycles.
//   2. A=3, B=9 -> Diff=4'hA, Bout=1; A=0, B=1 -> Diff=4'hF, Bout=1.
//   3. A=15,B=15 and A=0,B=0 -> Diff=0, Bout=0; A=15,B=0 -> Diff=15, Bout=0.
//   4. start held high continuously with A=7, B=2 -> done every 5 cycles, Diff=5;
//      start pulse with A=1, B=1 mid-SHIFT is ignored (result still 5).
//   5. reset asserted 2 cycles after start -> next cycle busy=0, done=0,
//      Diff=0, Bout=0; no done pulse follows; new op then completes normally.
//   6. Exhaustive: all 256 A,B pairs -> {Bout,Diff} == ({1'b0,A}-{1'b0,B}) mod 32,
//      counting mismatches; required count 0.

Source files
------------

// File: rtl/serial_subtractor_4_bit.sv
// Bit-serial unsigned subtractor: Diff = A - B computed LSB first, one bit per
// clock through a single borrow flop, with a start/busy/done handshake.
module serial_subtractor_4_bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] d_sr_q, d_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic a_bit, b_bit, d_bit, br_next;

    // One full-subtractor cell, reused for every bit position.
    assign a_bit   = a_sr_q[0];
    assign b_bit   = b_sr_q[0];
    assign d_bit   = a_bit ^ b_bit ^ br_q;
    assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        d_sr_d  = d_sr_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d  = A;
                    b_sr_d  = B;
                    d_sr_d  = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                d_sr_d = {d_bit, d_sr_q[WIDTH-1:1]};
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    // Publish on the edge entering DONE so outputs hold until the next result.
                    diff_d  = {d_bit, d_sr_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            d_sr_q  <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            d_sr_q  <= d_sr_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign Diff = diff_q;
    assign Bout = bout_q;

endmodule
